// File: rtl/dht11_pkg.sv
// Shared types and timing constants for the DHT11 single-wire sensor emulator.
// Durations are in microseconds; the frame is four measurement bytes plus a checksum.
package dht11_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HOST_LOW,
      RESP_DELAY,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      END_LOW
   } state_t;

   localparam int unsigned CNT_W        = 16;
   localparam int unsigned RESP_LOW_US  = 80;
   localparam int unsigned RESP_HIGH_US = 80;
   localparam int unsigned BIT_LOW_US   = 50;
   localparam int unsigned BIT0_HIGH_US = 26;
   localparam int unsigned BIT1_HIGH_US = 70;
   localparam int unsigned END_LOW_US   = 50;
   localparam int unsigned FRAME_BITS   = 40;

   // Byte-wise sum with the carry discarded.
   function automatic logic [7:0] frame_checksum(input logic [7:0] a, input logic [7:0] b,
                                                 input logic [7:0] c, input logic [7:0] d);
      logic [9:0] sum;
      sum = 10'(a) + 10'(b) + 10'(c) + 10'(d);
      return sum[7:0];
   endfunction

endpackage

// File: rtl/dht11_emu_if.sv
// Single-wire bus bundle for the DHT11 emulator: sensed level, open-drain pull and status.
// The master side is the host/bus model, the slave side is the emulated sensor.
interface dht11_emu_if;
   logic data_in;
   logic data_oe;
   logic busy;
   logic frame_done;
   logic start_err;

   modport master (output data_in, input data_oe, input busy, input frame_done, input start_err);
   modport slave  (input data_in, output data_oe, output busy, output frame_done, output start_err);
endinterface

// File: rtl/dht11_us_tick.sv
// Free-running prescaler producing a one-cycle tick every DIV clock cycles (1 us base).
module dht11_us_tick #(
   parameter int unsigned DIV = 50
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'((DIV > 0) ? DIV - 1 : 0);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/dht11_emu.sv
// DHT11 sensor emulator: answers a host start pulse with the 80/80 us response and a 40-bit frame.
// Optional macro DHT11_EMU_CRC_FAULT_EN adds CRC_FAULT, which corrupts checksum bit 0.
module dht11_emu
   import dht11_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ   = 50000000,
   parameter int unsigned MIN_START_US  = 18000,
   parameter int unsigned RESP_DELAY_US = 30
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic       DATA_IN,
   output logic       DATA_OE,
   input  logic [7:0] HUM_INT,
   input  logic [7:0] HUM_FLOAT,
   input  logic [7:0] TEMP_INT,
   input  logic [7:0] TEMP_FLOAT,
`ifdef DHT11_EMU_CRC_FAULT_EN
   input  logic       CRC_FAULT,
`endif
   output logic       BUSY,
   output logic       FRAME_DONE,
   output logic       START_ERR
);

   localparam int unsigned TICK_DIV = (CLK_FREQ_HZ >= 1000000) ? CLK_FREQ_HZ / 1000000 : 1;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [5:0]              bit_idx_q, bit_idx_d;
   logic [FRAME_BITS-1:0]   frame_q, frame_d;
   logic                    data_oe_q, data_oe_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    sync1_q, sync2_q, prev_q;
   logic                    tick, fall, rise, timer_done, crc_flip;
   logic [CNT_W-1:0]        dur;

   dht11_us_tick #(.DIV(TICK_DIV)) u_tick (
      .clk   (CLK),
      .rst_n (RST),
      .tick  (tick)
   );

`ifdef DHT11_EMU_CRC_FAULT_EN
   assign crc_flip = CRC_FAULT;
`else
   assign crc_flip = 1'b0;
`endif

   assign fall = prev_q & ~sync2_q;
   assign rise = ~prev_q & sync2_q;

   always_comb begin
      dur = '0;
      case (state_q)
         RESP_DELAY: dur = CNT_W'(RESP_DELAY_US);
         RESP_LOW:   dur = CNT_W'(RESP_LOW_US);
         RESP_HIGH:  dur = CNT_W'(RESP_HIGH_US);
         BIT_LOW:    dur = CNT_W'(BIT_LOW_US);
         BIT_HIGH:   dur = frame_q[FRAME_BITS-1] ? CNT_W'(BIT1_HIGH_US) : CNT_W'(BIT0_HIGH_US);
         END_LOW:    dur = CNT_W'(END_LOW_US);
         default:    dur = '0;
      endcase
   end

   assign timer_done = tick && (cnt_q == dur - CNT_W'(1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      frame_d   = frame_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (fall && EN) begin
               state_d = HOST_LOW;
               cnt_d   = '0;
            end
         end
         HOST_LOW: begin
            if (rise) begin
               if (cnt_q >= CNT_W'(MIN_START_US)) begin
                  state_d   = RESP_DELAY;
                  cnt_d     = '0;
                  bit_idx_d = '0;
                  frame_d   = {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT,
                               frame_checksum(HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT) ^ {7'b0, crc_flip}};
               end else begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end else if (tick && (cnt_q != '1)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            // Timed phases: bus level is ignored, only the tick counter moves the FSM.
            if (tick) cnt_d = timer_done ? '0 : cnt_q + CNT_W'(1);
            if (timer_done) begin
               case (state_q)
                  RESP_DELAY: state_d = RESP_LOW;
                  RESP_LOW:   state_d = RESP_HIGH;
                  RESP_HIGH:  state_d = BIT_LOW;
                  BIT_LOW:    state_d = BIT_HIGH;
                  BIT_HIGH: begin
                     frame_d   = {frame_q[FRAME_BITS-2:0], 1'b0};
                     bit_idx_d = bit_idx_q + 6'd1;
                     state_d   = (bit_idx_q == 6'(FRAME_BITS - 1)) ? END_LOW : BIT_LOW;
                  end
                  END_LOW: begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
      endcase

      data_oe_d = (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
      busy_d    = (state_d != IDLE) && (state_d != HOST_LOW);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         frame_q   <= '0;
         data_oe_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         prev_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         frame_q   <= frame_d;
         data_oe_q <= data_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         sync1_q   <= DATA_IN;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
      end
   end

   assign DATA_OE    = data_oe_q;
   assign BUSY       = busy_q;
   assign FRAME_DONE = done_q;
   assign START_ERR  = err_q;

endmodule
